bin_to_thto_ctrl: RTL
=====================

BIN_TO_THTO_CTRL -- requirements
Module: bin_to_thto_ctrl

Interface
REQ-001 SHALL have parameter IVW, default 12, meaning binary input width (switches).
REQ-002 SHALL have parameter OTHW, default 4, meaning number of BCD digits/displays.
REQ-003 SHALL have parameter DPW, default 7, meaning segment count per display.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  conversion request, sampled each cycle.
REQ-007 SHALL have port ini_val  input  IVW  binary value to convert.
REQ-008 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking new results.
REQ-010 SHALL have port bcd_out  output  OTHW*4  registered BCD digits; digit 0 (ones) in bits [3:0].
REQ-011 SHALL have port display  output  OTHW*DPW  registered 7-segment codes, active-low, segment a at bit 0, display 0 = ones.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, SHIFT, DONE.
REQ-013 IDLE: busy=0; start=1 -> LOAD next cycle; otherwise stay.
REQ-014 LOAD: busy=1; working register (width IVW+OTHW*4) := {OTHW*4 zeros, ini_val}; iteration counter := 0; -> SHIFT.
REQ-015 SHIFT: busy=1; per cycle, each BCD nibble >=5 gets +3, then whole working register shifts left 1; counter +1; after IVW SHIFT cycles -> DONE.
REQ-016 DONE: busy=1; bcd_out and display load from working register upper OTHW*4 bits on entry; done=1 for this cycle only; -> IDLE.
REQ-017 Latency: start high in IDLE at cycle 0 -> done=1 in cycle IVW+2 (cycle 14 at default); next start accepted in cycle IVW+3.
REQ-018 start while busy=1 SHALL be ignored, not queued.
REQ-019 ini_val SHALL be sampled only in LOAD; later changes do not affect the running conversion.
REQ-020 bcd_out and display SHALL hold previous results until the next DONE.
REQ-021 Segment decode SHALL map digits 0-9 to standard patterns; codes 10-15 (unreachable) SHALL drive all segments off.
REQ-022 Parameters SHALL satisfy 2**IVW-1 <= 10**OTHW-1; elaboration SHALL fail otherwise.
REQ-023 Counter width SHALL be $clog2(IVW+1); no wrap occurs within a conversion.

Reset
REQ-024 rst=1 at any edge SHALL force IDLE, busy=0, done=0, bcd_out=0, working register=0, counter=0, overriding start.
REQ-025 display SHALL reset to the code for digit 0 on every display.
REQ-026 Reset mid-conversion SHALL abort with no done pulse; first start after rst release SHALL behave per REQ-017.

Configuration
REQ-027 Macro AUTO_CONV_EN: when defined, a last-converted register (IVW bits, reset 0, loaded in LOAD) SHALL exist, and IDLE SHALL also go to LOAD when ini_val differs from it, with or without start.
REQ-028 Without AUTO_CONV_EN, only start SHALL trigger conversions and no last-converted register SHALL exist.

Verification
REQ-029 Reset, ini_val=12'd0, pulse start -> done in cycle 14, bcd_out=16'h0000, all displays show "0".
REQ-030 ini_val=12'd4095, start -> done in cycle 14, bcd_out=16'h4095, busy high cycles 1-14.
REQ-031 ini_val=12'd1234, start; change ini_val to 12'd999 in cycle 5; start again in cycle 6 -> bcd_out=16'h1234, single done pulse, no second conversion.
REQ-032 Start 12'd500, assert rst in cycle 8 -> no done, bcd_out=0, busy=0 next cycle; start with 12'd42 -> bcd_out=16'h0042 after 14 cycles.
REQ-033 Back-to-back: start held high continuously with ini_val=12'd7 -> done pulses every 15 cycles, bcd_out=16'h0007.
REQ-034 With AUTO_CONV_EN, start=0, ini_val changes 0 -> 12'd256 -> conversion begins unprompted, bcd_out=16'h0256; ini_val held -> no further conversions.

Source files
------------

// File: rtl/bin_to_thto_ctrl.sv
// ============================================================================
// Module      : bin_to_thto_ctrl
// Description : Sequential binary-to-BCD converter (shift-and-add-3). It also
//               produces registered active-low 7-segment codes, one display
//               per BCD digit.
//               Optional macro AUTO_CONV_EN: a new conversion also starts when
//               ini_val differs from the value converted last.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_to_thto_ctrl #(
  parameter int IVW  = 12,
  parameter int OTHW = 4,
  parameter int DPW  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IVW-1:0]        ini_val,
  output logic                  busy,
  output logic                  done,
  output logic [OTHW*4-1:0]     bcd_out,
  output logic [OTHW*DPW-1:0]   display
);

  localparam int BW = OTHW * 4;
  localparam int WW = IVW + BW;
  localparam int CW = $clog2(IVW + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [CW-1:0] LAST_CNT = CW'(IVW - 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] MAX_IN  = (64'd1 << IVW) - 64'd1;
  localparam logic [63:0] MAX_OUT = pow10(OTHW) - 64'd1;

  // The largest binary input must fit in the available BCD digits.
  generate
    if (MAX_IN > MAX_OUT) begin : g_param_fail
      $error("bin_to_thto_ctrl: OTHW too small for IVW");
    end
  endgenerate

  // Active-low segment pattern, segment a at bit 0; non-decimal codes blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  logic [1:0]          r_state;
  logic [WW-1:0]       r_work;
  logic [CW-1:0]       r_cnt;
  logic                r_done;
  logic [BW-1:0]       r_bcd;
  logic [OTHW*DPW-1:0] r_disp;

  logic [WW-1:0]       w_adj;
  logic [WW-1:0]       w_shift;
  logic [OTHW*DPW-1:0] w_next_disp;
  logic [OTHW*DPW-1:0] w_zero_disp;
  logic                w_trigger;

  // One shift-and-add-3 step: correct every BCD nibble, then shift left.
  always_comb begin
    w_adj = r_work;
    for (int n = 0; n < OTHW; n++) begin
      if (r_work[IVW+4*n +: 4] >= 4'd5)
        w_adj[IVW+4*n +: 4] = r_work[IVW+4*n +: 4] + 4'd3;
    end
    w_shift = w_adj << 1;
  end

  // Per-display decode of the post-shift digits; extra segments stay off.
  generate
    for (genvar g = 0; g < OTHW; g++) begin : g_disp
      logic [6:0] w_pat;
      logic [6:0] w_zero;
      assign w_pat  = seg7(w_shift[IVW+4*g +: 4]);
      assign w_zero = seg7(4'd0);
      if (DPW > 7) begin : g_wide
        assign w_next_disp[g*DPW +: DPW] = {{(DPW-7){1'b1}}, w_pat};
        assign w_zero_disp[g*DPW +: DPW] = {{(DPW-7){1'b1}}, w_zero};
      end else begin : g_narrow
        assign w_next_disp[g*DPW +: DPW] = w_pat[DPW-1:0];
        assign w_zero_disp[g*DPW +: DPW] = w_zero[DPW-1:0];
      end
    end
  endgenerate

`ifdef AUTO_CONV_EN
  logic [IVW-1:0] r_last;

  // Remember the value most recently taken into a conversion.
  always_ff @(posedge clk) begin
    if (rst)
      r_last <= '0;
    else if (r_state == LOAD)
      r_last <= ini_val;
  end

  assign w_trigger = start | (ini_val != r_last);
`else
  assign w_trigger = start;
`endif

  // Conversion sequencer; results are captured on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_work  <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_bcd   <= '0;
      r_disp  <= w_zero_disp;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_trigger) r_state <= LOAD;
        end
        LOAD: begin
          r_work  <= {{BW{1'b0}}, ini_val};
          r_cnt   <= '0;
          r_state <= SHIFT;
        end
        SHIFT: begin
          r_work <= w_shift;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == LAST_CNT) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_bcd   <= w_shift[WW-1 -: BW];
            r_disp  <= w_next_disp;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy    = (r_state != IDLE);
  assign done    = r_done;
  assign bcd_out = r_bcd;
  assign display = r_disp;

endmodule

`default_nettype wire
